inverse_dft_engine: RTL and testbench

Streaming inverse DFT: accepts one N-point complex frame serially, computes x[n] = (1/N)·Σ X[k]·e^{+j2πkn/N} with a single time-multiplexed complex MAC, and emits N complex time-domain samples serially under valid/ready backpressure. It sits on the receive side of the spectral path and undoes the forward DFT matrix block. The unit is frame-based and non-overlapping: load, compute and emit, then load again.

---
 rtl/inverse_dft_engine.sv | 177 +++++++++++++++++
 tb/tb_inverse_dft_engine.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverse_dft_engine.sv
// Streaming N-point inverse DFT with one time-multiplexed complex MAC: load a frame, then compute and emit one sample per pass.
// Optional build macro IDFT_ROUND_EN switches the output scaling from floor to round-half-up.
module inverse_dft_engine #(
  parameter int N  = 16,
  parameter int W  = 16,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 out_last,
  output logic                 busy
);

  localparam int LOGN = $clog2(N);
  localparam int PW   = DW + W;
  localparam int AW   = DW + W + LOGN + 1;
  localparam int SH   = W - 2 + LOGN;
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);
  localparam logic signed [AW-1:0] MAXV = (AW'(1) <<< (DW - 1)) - AW'(1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;
`ifdef IDFT_ROUND_EN
  localparam logic signed [AW-1:0] RND = AW'(1) <<< (SH - 1);
`endif
  localparam real TWO_PI = 6.283185307179586;
  localparam real SCALE  = 2.0 ** (W - 2);

  typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

  state_t state, state_next;
  logic [LOGN-1:0] k_wr, k, n, m;
  logic signed [AW-1:0] acc_re, acc_im, acc_re_next, acc_im_next;
  logic signed [DW-1:0] buf_re [N];
  logic signed [DW-1:0] buf_im [N];
  logic signed [W-1:0]  cos_rom [N];
  logic signed [W-1:0]  sin_rom [N];
  logic signed [DW-1:0] x_re, x_im;
  logic signed [W-1:0]  c_tw, s_tw;
  logic signed [PW-1:0] p_rc, p_is, p_rs, p_ic;
  logic in_fire;

  function automatic int round_real(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic logic signed [DW-1:0] scale_sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] t;
`ifdef IDFT_ROUND_EN
    t = (a + RND) >>> SH;
`else
    t = a >>> SH;
`endif
    if (t > MAXV) t = MAXV;
    else if (t < MINV) t = MINV;
    return t[DW-1:0];
  endfunction

  // Twiddle table e^{+j2pi m/N}, fixed at elaboration
  for (genvar i = 0; i < N; i++) begin : g_twiddle
    localparam real ANG = TWO_PI * i / N;
    localparam int  CI  = round_real($cos(ANG) * SCALE);
    localparam int  SI  = round_real($sin(ANG) * SCALE);
    assign cos_rom[i] = CI[W-1:0];
    assign sin_rom[i] = SI[W-1:0];
  end

  assign in_fire = in_valid && (state == LOAD);

  assign x_re = buf_re[k];
  assign x_im = buf_im[k];
  assign c_tw = cos_rom[m];
  assign s_tw = sin_rom[m];
  assign p_rc = PW'(x_re) * PW'(c_tw);
  assign p_is = PW'(x_im) * PW'(s_tw);
  assign p_rs = PW'(x_re) * PW'(s_tw);
  assign p_ic = PW'(x_im) * PW'(c_tw);
  assign acc_re_next = acc_re + AW'(p_rc) - AW'(p_is);
  assign acc_im_next = acc_im + AW'(p_rs) + AW'(p_ic);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      LOAD: begin
        in_ready = rst_n;
        if (in_valid && k_wr == LAST) state_next = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (k == LAST) state_next = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = (n == LAST) ? LOAD : MAC;
      end
      default: state_next = LOAD;
    endcase
  end

  // Buffer needs no reset: an aborted frame is simply overwritten by the next one
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_re[k_wr] <= in_re;
      buf_im[k_wr] <= in_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_wr     <= '0;
      k        <= '0;
      n        <= '0;
      m        <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
      out_re   <= '0;
      out_im   <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            k_wr <= k_wr + 1'b1;
            if (k_wr == LAST) begin
              n      <= '0;
              k      <= '0;
              m      <= '0;
              acc_re <= '0;
              acc_im <= '0;
            end
          end
        end
        MAC: begin
          acc_re <= acc_re_next;
          acc_im <= acc_im_next;
          k      <= k + 1'b1;
          m      <= m + n;
          // The final product is folded in here so the result is registered on entry to EMIT
          if (k == LAST) begin
            out_re   <= scale_sat(acc_re_next);
            out_im   <= scale_sat(acc_im_next);
            out_last <= (n == LAST);
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_last <= 1'b0;
            if (n != LAST) begin
              n      <= n + 1'b1;
              k      <= '0;
              m      <= '0;
              acc_re <= '0;
              acc_im <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_dft_engine.sv
// Directed self-checking bench for inverse_dft_engine: impulse, DC, tone, backpressure, reset abort and saturation (DW=8 instance).
`timescale 1ns/1ps
module tb_inverse_dft_engine;
  localparam int  N   = 16;
  localparam int  DW  = 32;
  localparam int  SDW = 8;
  localparam real PI  = 3.141592653589793;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [DW-1:0] in_re, in_im, out_re, out_im;
  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_busy;
  logic signed [SDW-1:0] s_in_re, s_in_im, s_out_re, s_out_im;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic signed [DW-1:0] fr_re [N];
  logic signed [DW-1:0] fr_im [N];
  logic signed [DW-1:0] got_re [N];
  logic signed [DW-1:0] got_im [N];
  logic got_last [N];
  int   got_cyc [N];
  logic signed [DW-1:0] hold_re [8];
  logic signed [DW-1:0] hold_im [8];
  logic hold_valid [8];
  int first_cyc, accept_cyc, busy_ready;
  bit timed_out;
  logic ready_after;

  inverse_dft_engine #(.N(N), .W(16), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy)
  );

  inverse_dft_engine #(.N(N), .W(16), .DW(SDW)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_re(s_in_re), .in_im(s_in_im),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_re(s_out_re), .out_im(s_out_im),
    .out_last(s_out_last), .busy(s_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic send_frame(input int count);
    int guard;
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b1;
      in_re = fr_re[i];
      in_im = fr_im[i];
      guard = 0;
      while (!in_ready && guard < 500) begin
        @(posedge clk); #1;
        guard++;
      end
      @(posedge clk); #1;
    end
    accept_cyc = cyc;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
  endtask

  task automatic collect(input int hold_idx, input int hold_len, input bit drive_in);
    int idx, guard, held;
    idx = 0; guard = 0; held = 0;
    first_cyc = -1; timed_out = 0; busy_ready = 0;
    out_ready = 1'b1;
    if (drive_in) begin
      in_valid = 1'b1;
      in_re = 32'sd999;
      in_im = -32'sd999;
    end
    while (idx < N) begin
      if (guard >= 3000) begin
        timed_out = 1;
        break;
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (idx == hold_idx && held < hold_len) begin
          out_ready = 1'b0;
          hold_valid[held] = out_valid;
          hold_re[held] = out_re;
          hold_im[held] = out_im;
          held++;
        end else begin
          out_ready = 1'b1;
          got_re[idx] = out_re;
          got_im[idx] = out_im;
          got_last[idx] = out_last;
          got_cyc[idx] = cyc;
          idx++;
        end
      end
      if (in_ready) busy_ready++;
      @(posedge clk); #1;
      guard++;
    end
    ready_after = in_ready;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    out_ready = 1'b1;
  endtask

  task automatic load_impulse();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = (i == 0) ? 32'sd16 : 32'sd0;
      fr_im[i] = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_re = '0; s_in_im = '0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (out_re !== 32'sd0 || out_im !== 32'sd0) begin errors++; $display("[TB] FAIL reset_out_data got=(%0d,%0d) exp=(0,0)", out_re, out_im); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    load_impulse();
    send_frame(N);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL impulse_busy got=%b exp=1", busy); end
    collect(-1, 0, 0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL impulse_timeout got=timeout exp=16 outputs"); end
    checks++; if (first_cyc - accept_cyc != N) begin errors++; $display("[TB] FAIL impulse_latency got=%0d exp=%0d", first_cyc - accept_cyc, N); end
    checks++; if (got_cyc[1] - got_cyc[0] != N + 1) begin errors++; $display("[TB] FAIL impulse_spacing got=%0d exp=%0d", got_cyc[1] - got_cyc[0], N + 1); end
    checks++; if (busy_ready != 0) begin errors++; $display("[TB] FAIL impulse_ready_busy got=%0d exp=0", busy_ready); end
    checks++; if (ready_after !== 1'b1) begin errors++; $display("[TB] FAIL impulse_ready_after got=%b exp=1", ready_after); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_re[i] !== 32'sd1 || got_im[i] !== 32'sd0) begin
        errors++; $display("[TB] FAIL impulse_out[%0d] got=(%0d,%0d) exp=(1,0)", i, got_re[i], got_im[i]);
      end
      checks++;
      if (got_last[i] !== (i == N - 1)) begin
        errors++; $display("[TB] FAIL impulse_last[%0d] got=%b exp=%b", i, got_last[i], (i == N - 1));
      end
    end
  endtask

  task automatic test_dc();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 32'sd100;
      fr_im[i] = '0;
    end
    send_frame(N);
    collect(-1, 0, 0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL dc_timeout got=timeout exp=16 outputs"); end
    checks++; if (got_re[0] !== 32'sd100 || got_im[0] !== 32'sd0) begin errors++; $display("[TB] FAIL dc_out[0] got=(%0d,%0d) exp=(100,0)", got_re[0], got_im[0]); end
    for (int i = 1; i < N; i++) begin
      checks++;
      if (got_re[i] > 1 || got_re[i] < -1 || got_im[i] > 1 || got_im[i] < -1) begin
        errors++; $display("[TB] FAIL dc_out[%0d] got=(%0d,%0d) exp=(0,0)+-1", i, got_re[i], got_im[i]);
      end
    end
  endtask

  task automatic load_tone();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = (i == 1) ? 32'sd1600 : 32'sd0;
      fr_im[i] = '0;
    end
  endtask

  task automatic test_tone();
    logic signed [DW-1:0] ex_re [4];
    logic signed [DW-1:0] ex_im [4];
    real er, ei, dr, di;
    ex_re[0] = 100; ex_im[0] = 0;
    ex_re[1] = 0;   ex_im[1] = 100;
    ex_re[2] = -100; ex_im[2] = 0;
    ex_re[3] = 0;   ex_im[3] = -100;
    load_tone();
    send_frame(N);
    collect(-1, 0, 0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL tone_timeout got=timeout exp=16 outputs"); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (i % 4 == 0) begin
        if (got_re[i] !== ex_re[i/4] || got_im[i] !== ex_im[i/4]) begin
          errors++; $display("[TB] FAIL tone_out[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, got_re[i], got_im[i], ex_re[i/4], ex_im[i/4]);
        end
      end else begin
        er = 100.0 * $cos(2.0 * PI * i / N);
        ei = 100.0 * $sin(2.0 * PI * i / N);
        dr = $itor(got_re[i]) - er;
        di = $itor(got_im[i]) - ei;
        if (dr > 1.0 || dr < -1.0 || di > 1.0 || di < -1.0) begin
          errors++; $display("[TB] FAIL tone_out[%0d] got=(%0d,%0d) exp=(%0.2f,%0.2f)+-1", i, got_re[i], got_im[i], er, ei);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    real er, ei, dr, di;
    load_tone();
    send_frame(N);
    collect(3, 5, 1);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL bp_timeout got=timeout exp=16 outputs"); end
    checks++; if (busy_ready != 0) begin errors++; $display("[TB] FAIL bp_in_ready_busy got=%0d cycles exp=0", busy_ready); end
    checks++; if (ready_after !== 1'b1) begin errors++; $display("[TB] FAIL bp_in_ready_after got=%b exp=1", ready_after); end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (hold_valid[j] !== 1'b1 || hold_re[j] !== got_re[3] || hold_im[j] !== got_im[3]) begin
        errors++; $display("[TB] FAIL bp_hold[%0d] got=(%b,%0d,%0d) exp=(1,%0d,%0d)", j, hold_valid[j], hold_re[j], hold_im[j], got_re[3], got_im[3]);
      end
    end
    for (int i = 0; i < N; i++) begin
      er = 100.0 * $cos(2.0 * PI * i / N);
      ei = 100.0 * $sin(2.0 * PI * i / N);
      dr = $itor(got_re[i]) - er;
      di = $itor(got_im[i]) - ei;
      checks++;
      if (dr > 1.0 || dr < -1.0 || di > 1.0 || di < -1.0) begin
        errors++; $display("[TB] FAIL bp_out[%0d] got=(%0d,%0d) exp=(%0.2f,%0.2f)+-1", i, got_re[i], got_im[i], er, ei);
      end
    end
    load_impulse();
    send_frame(N);
    collect(-1, 0, 0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (timed_out || got_re[i] !== 32'sd1 || got_im[i] !== 32'sd0) begin
        errors++; $display("[TB] FAIL bp_followup[%0d] got=(%0d,%0d) exp=(1,0)", i, got_re[i], got_im[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 32'sd500 + i;
      fr_im[i] = -32'sd77;
    end
    send_frame(7);
    #2;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    load_impulse();
    send_frame(N);
    collect(-1, 0, 0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL midreset_timeout got=timeout exp=16 outputs"); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_re[i] !== 32'sd1 || got_im[i] !== 32'sd0 || got_last[i] !== (i == N - 1)) begin
        errors++; $display("[TB] FAIL midreset_out[%0d] got=(%0d,%0d,last=%b) exp=(1,0,last=%b)", i, got_re[i], got_im[i], got_last[i], (i == N - 1));
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [SDW-1:0] r1, exp_r1;
    int seen, guard;
    logic saw_last;
    real c, s;
    for (int pass = 0; pass < 2; pass++) begin
      exp_r1 = (pass == 0) ? 8'sd127 : -8'sd128;
      for (int k = 0; k < N; k++) begin
        c = $cos(2.0 * PI * k / N);
        s = $sin(2.0 * PI * k / N);
        s_in_valid = 1'b1;
        s_in_re = (c >= 0.0) ? 8'sd127 : -8'sd127;
        s_in_im = (s > 0.0) ? -8'sd127 : 8'sd127;
        if (pass == 1) begin
          s_in_re = -s_in_re;
          s_in_im = -s_in_im;
        end
        guard = 0;
        while (!s_in_ready && guard < 500) begin
          @(posedge clk); #1;
          guard++;
        end
        @(posedge clk); #1;
      end
      s_in_valid = 1'b0;
      seen = 0; guard = 0; r1 = '0; saw_last = 1'b0;
      while (seen < N && guard < 3000) begin
        if (s_out_valid) begin
          if (seen == 1) r1 = s_out_re;
          if (seen == N - 1) saw_last = s_out_last;
          seen++;
        end
        @(posedge clk); #1;
        guard++;
      end
      checks++;
      if (seen != N || r1 !== exp_r1) begin
        errors++; $display("[TB] FAIL sat_out1_re pass%0d got=%0d (outputs=%0d) exp=%0d", pass, r1, seen, exp_r1);
      end
      checks++;
      if (saw_last !== 1'b1 || s_busy !== 1'b0) begin
        errors++; $display("[TB] FAIL sat_frame_end pass%0d got=(last=%b,busy=%b) exp=(1,0)", pass, saw_last, s_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_tone();
    test_backpressure();
    test_reset_midframe();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
